// File: rtl/spidac_pkg.sv
// Shared TLC5615 frame constants and responder FSM states, also used by the DAC driver.
package spidac_pkg;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned DATA_BITS   = 10;
  localparam int unsigned DATA_LSB    = 2;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = $clog2(FRAME_BITS) + 2;
  localparam int unsigned FCNT_W      = 8;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spidac_rx_sync.sv
// spi_in_sync: STAGES-deep synchronizer for one asynchronous SPI input with rise/fall detect.
// Ports:
//   clk, Reset  system clock, asynchronous active-low reset
//   d           raw asynchronous input
//   q           synchronized level (last stage)
//   rise_c      q rose this cycle (last stage vs one extra flop)
//   fall_c      q fell this cycle
module spi_in_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic Reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync;
  logic              last;

  // Synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync <= {STAGES{RST_VAL}};
      last <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      last <= sync[STAGES-1];
    end
  end

  assign q      = sync[STAGES-1];
  assign rise_c = q & ~last;
  assign fall_c = ~q & last;

endmodule

// File: rtl/spidac_rx.sv
// spidac_rx: SPI responder for TLC5615 16-bit write frames {4'b0, D[9:0], 2'b0}, MSB first,
// SCLK idle low. Presents the payload in the clk domain and drives a TLC5615-style delayed DOUT.
// Ports:
//   clk, Reset  system clock (>= 8x SCLK), asynchronous active-low reset
//   spi_sclk    SPI clock from master (asynchronous)
//   spi_ncs     chip select, active low
//   spi_din     serial data from master
//   spi_dout    previous frame, MSB first; held while ncs is high
//   rx_data     last valid payload, held
//   rx_valid    1-clk pulse when rx_data updates
//   rx_err      1-clk pulse when a frame closes with a bit count other than FRAME_BITS
//   rx_busy     high while a frame is open
//   frame_cnt   valid frame count, wraps
module spidac_rx
  import spidac_pkg::*;
(
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 spi_sclk,
  input  logic                 spi_ncs,
  input  logic                 spi_din,
  output logic                 spi_dout,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic                 rx_busy,
  output logic [FCNT_W-1:0]    frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic sclk_lvl_unused, sclk_rise_c, sclk_fall_c;
  logic ncs_q, ncs_rise_c, ncs_fall_c;
  logic din_q, din_rise_unused, din_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .Reset(Reset), .d(spi_sclk),
    .q(sclk_lvl_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .Reset(Reset), .d(spi_ncs),
    .q(ncs_q), .rise_c(ncs_rise_c), .fall_c(ncs_fall_c)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .Reset(Reset), .d(spi_din),
    .q(din_q), .rise_c(din_rise_unused), .fall_c(din_fall_unused)
  );

  // The ncs synchronizer resets to 1, so its output is not a real observation of the pin
  // until the chain has been flushed; S_WAIT must not trust it before then, otherwise a chip
  // select held low across reset release would look like high-then-fall and open a false frame.
  logic [SYNC_STAGES:0] flush;
  logic                 primed;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) flush <= '0;
    else        flush <= {flush[SYNC_STAGES-1:0], 1'b1};
  end

  assign primed = flush[SYNC_STAGES];

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  // Frame FSM, shift register and counters
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_WAIT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      spi_dout  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      rx_busy   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        S_WAIT: begin
          if (primed && ncs_q) state <= S_IDLE;
        end
        S_IDLE: begin
          // shift_reg keeps the previous frame so it can be replayed on spi_dout
          if (ncs_fall_c) begin
            state    <= S_SHIFT;
            bit_cnt  <= '0;
            rx_busy  <= 1'b1;
            spi_dout <= shift_reg[FRAME_BITS-1];
          end
        end
        S_SHIFT: begin
          if (sclk_rise_c) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], din_q};
            // Saturate so over-long frames never wrap back onto FRAME_BITS
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (sclk_fall_c) spi_dout <= shift_reg[FRAME_BITS-1];
          if (ncs_rise_c) begin
            state   <= S_DONE;
            rx_busy <= 1'b0;
          end
        end
        S_DONE: begin
          if (bit_cnt == CNT_FULL) begin
            rx_data   <= shift_reg[DATA_LSB +: DATA_BITS];
            rx_valid  <= 1'b1;
            frame_cnt <= frame_cnt + FCNT_W'(1);
          end else begin
            rx_err <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spidac_rx.sv
// Randomized self-checking bench for spidac_rx with a frame-level reference model.
module tb_spidac_rx;
  import spidac_pkg::*;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_ncs = 1'b1;
  logic       spi_din = 1'b0;
  logic       spi_dout;
  logic [9:0] rx_data;
  logic       rx_valid, rx_err, rx_busy;
  logic [7:0] frame_cnt;

  spidac_rx dut (
    .clk(clk), .Reset(Reset), .spi_sclk(spi_sclk), .spi_ncs(spi_ncs), .spi_din(spi_din),
    .spi_dout(spi_dout), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .rx_busy(rx_busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected frame-close events: cycle on which the pulse must be visible, and its kind
  typedef struct {
    int         at;
    bit         ok;
    logic [9:0] data;
  } ev_t;
  ev_t evq[$];

  logic [9:0]  m_data = '0;
  int          m_cnt = 0;
  logic [15:0] m_prev = '0;
  logic        m_hold = 1'b0;
  int          valid_seen = 0;
  int          err_seen = 0;
  logic [15:0] obs_word = '0;
  logic        ev_v, ev_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit k of the stream seen on the internal shift path: previous frame MSB first, then new bits
  function automatic logic stream_bit(input logic [15:0] prev, input logic [127:0] bits,
                                      input int n, input int k);
    int idx;
    if (k < 16) return prev[15-k];
    idx = n - 1 - (k - 16);
    return bits[idx];
  endfunction

  // One SCLK period: data set up, 4 clk high, 4 clk low
  task automatic clock_bit(input logic b);
    spi_din = b;
    tick(1);
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
    tick(3);
  endtask

  // Send n bits (bits[n-1] first) as one frame and record what the DUT must report
  task automatic frame(input logic [127:0] bits, input int n);
    logic [15:0] prev;
    logic [15:0] nxt;
    ev_t         e;
    logic        exp_d;
    prev = m_prev;
    spi_ncs = 1'b0;
    tick(8);
    for (int k = 0; k < n; k++) begin
      spi_din = bits[n-1-k];
      tick(1);
      exp_d = stream_bit(prev, bits, n, k);
      check("dout", 64'(spi_dout), 64'(exp_d));
      check("busy", 64'(rx_busy), 64'(1));
      if (k < 16) obs_word[15-k] = spi_dout;
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
      tick(3);
    end
    tick(1);
    exp_d = stream_bit(prev, bits, n, n);
    check("dout_end", 64'(spi_dout), 64'(exp_d));
    spi_ncs = 1'b1;
    e.at = cyc + 4;
    e.ok = (n == 16);
    e.data = bits[11:2];
    evq.push_back(e);
    for (int j = 0; j < 16; j++) nxt[15-j] = stream_bit(prev, bits, n, n + j);
    m_prev = nxt;
    m_hold = exp_d;
    tick(16);
    check("busy_idle", 64'(rx_busy), 64'(0));
  endtask

  task automatic model_reset();
    evq.delete();
    m_data = '0;
    m_cnt = 0;
    m_prev = '0;
    m_hold = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    model_reset();
    tick(4);
    Reset = 1'b1;
    tick(10);
  endtask

  // Per-cycle comparison of the clk-domain outputs against the model
  always @(negedge clk) begin
    ev_v = 1'b0;
    ev_e = 1'b0;
    if (evq.size() > 0 && evq[0].at == cyc) begin
      if (evq[0].ok) begin
        ev_v = 1'b1;
        m_data = evq[0].data;
        m_cnt = (m_cnt + 1) % 256;
      end else begin
        ev_e = 1'b1;
      end
      void'(evq.pop_front());
    end
    if (rx_valid === 1'b1) valid_seen++;
    if (rx_err === 1'b1) err_seen++;
    check("outputs", 64'({rx_valid, rx_err, rx_data, frame_cnt}), 64'({ev_v, ev_e, m_data, 8'(m_cnt)}));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [127:0] r;
    int           v0, e0;

    // Reset state
    tick(3);
    check("reset_state", 64'({spi_dout, rx_data, rx_valid, rx_err, rx_busy, frame_cnt}), 64'(0));
    Reset = 1'b1;
    tick(10);

    // Test 1: single valid frame
    valid_seen = 0;
    err_seen = 0;
    frame(128'h0AA8, 16);
    check("t1_data", 64'(rx_data), 64'(682));
    check("t1_cnt", 64'(frame_cnt), 64'(1));
    check("t1_valid", 64'(valid_seen), 64'(1));
    check("t1_err", 64'(err_seen), 64'(0));

    // Test 3: short, long and very long frames (80 bits would alias a non-saturating counter)
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    frame(r, 15);
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    frame(r, 17);
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    frame(r, 80);
    check("t3_err", 64'(err_seen), 64'(3));
    check("t3_valid", 64'(valid_seen), 64'(1));
    check("t3_data", 64'(rx_data), 64'(682));
    check("t3_cnt", 64'(frame_cnt), 64'(1));

    // Test 2: back-to-back frames, second frame replays the first on dout
    do_reset();
    frame(128'h0FF0, 16);
    check("t2_data1", 64'(rx_data), 64'(1020));
    frame(128'h0000, 16);
    check("t2_data2", 64'(rx_data), 64'(0));
    check("t2_cnt", 64'(frame_cnt), 64'(2));
    check("t2_dout_word", 64'(obs_word), 64'(16'h0FF0));

    // Test 4: reset mid-frame, released with ncs low
    do_reset();
    v0 = valid_seen;
    e0 = err_seen;
    spi_ncs = 1'b0;
    tick(8);
    for (int k = 0; k < 8; k++) clock_bit(1'($urandom_range(0, 1)));
    Reset = 1'b0;
    model_reset();
    tick(3);
    Reset = 1'b1;
    tick(2);
    for (int k = 0; k < 8; k++) begin
      clock_bit(1'($urandom_range(0, 1)));
      check("t4_dout", 64'(spi_dout), 64'(0));
      check("t4_busy", 64'(rx_busy), 64'(0));
    end
    spi_ncs = 1'b1;
    tick(16);
    check("t4_no_event", 64'({valid_seen, err_seen}), 64'({v0, e0}));
    frame(128'h0AA8, 16);
    check("t4_data", 64'(rx_data), 64'(682));
    check("t4_cnt", 64'(frame_cnt), 64'(1));

    // Test 5: SCLK with ncs high is ignored; 0-bit frame gives rx_err
    e0 = err_seen;
    for (int k = 0; k < 20; k++) clock_bit(1'($urandom_range(0, 1)));
    check("t5_dout_hold", 64'(spi_dout), 64'(m_hold));
    check("t5_busy", 64'(rx_busy), 64'(0));
    frame(128'h0, 0);
    check("t5_err", 64'(err_seen - e0), 64'(1));
    check("t5_data", 64'(rx_data), 64'(682));
    check("t5_cnt", 64'(frame_cnt), 64'(1));

    // Test 6: 256 random valid frames, counter wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      r = 128'($urandom_range(0, 65535));
      frame(r, 16);
      if (i == 254) check("t6_cnt255", 64'(frame_cnt), 64'(255));
    end
    check("t6_cnt_wrap", 64'(frame_cnt), 64'(0));
    check("t6_data", 64'(rx_data), 64'(r[11:2]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
